// File: rtl/cnn_pkg.sv
// Shared CNN types: pooling FSM states and controller layer-select constants.
package cnn_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ROW_EVEN = 2'd1,
    ROW_ODD  = 2'd2,
    DRAIN    = 2'd3
  } pool_state_t;

  localparam logic FULLY_CONVOL = 1'b0;
  localparam logic POOLING      = 1'b1;

endpackage

// File: rtl/pool_line_buffer.sv
// One-row partial-result store: synchronous write, combinational read, no reset on storage.
module pool_line_buffer #(
  parameter int unsigned Width = 16,
  parameter int unsigned Depth = 14,
  parameter int unsigned AddrW = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AddrW-1:0] waddr,
  input  logic [Width-1:0] wdata,
  input  logic [AddrW-1:0] raddr,
  output logic [Width-1:0] rdata
);

  logic [Width-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pooling_unit.sv
// 2x2 stride-2 pooling stage; max pooling by default, average pooling when POOL_AVG_EN is defined.
module pooling_unit
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned FMAP_WIDTH  = 28,
  parameter int unsigned FMAP_HEIGHT = 28
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pooling_signal,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic                  out_ready,
  output logic                  ready_write_from_pooling,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  frame_done
);

`ifdef POOL_AVG_EN
  localparam int unsigned BufW = DATA_WIDTH + 1;
`else
  localparam int unsigned BufW = DATA_WIDTH;
`endif
  localparam int unsigned Depth = FMAP_WIDTH / 2;
  localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned ColW  = $clog2(FMAP_WIDTH);
  localparam int unsigned RowW  = $clog2(FMAP_HEIGHT);

  pool_state_t state_q, state_d;
  logic [ColW-1:0]       col_q;
  logic [RowW-1:0]       row_q;
  logic [DATA_WIDTH-1:0] pix_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  out_valid_q;
  logic                  frame_done_q, frame_done_d;

  logic             accept, col_last, row_last, wr_en, emit;
  logic [AddrW-1:0] pair_idx;
  logic [BufW-1:0]  pair_res, buf_rd;
  logic [DATA_WIDTH-1:0] pool_res;

  // Stall only while a result is stuck; a pop and a new result may share a cycle.
  assign in_ready = pooling_signal && (state_q == ROW_EVEN || state_q == ROW_ODD) &&
                    !(out_valid_q && !out_ready);
  assign accept   = in_valid && in_ready;
  assign col_last = (col_q == ColW'(FMAP_WIDTH - 1));
  assign row_last = (row_q == RowW'(FMAP_HEIGHT - 1));
  assign wr_en    = accept && (state_q == ROW_EVEN) && col_q[0];
  assign emit     = accept && (state_q == ROW_ODD) && col_q[0];
  assign pair_idx = AddrW'(col_q >> 1);

`ifdef POOL_AVG_EN
  logic [DATA_WIDTH+1:0] sum4;
  assign pair_res = {in_data[DATA_WIDTH-1], in_data} + {pix_q[DATA_WIDTH-1], pix_q};
  assign sum4     = {pair_res[BufW-1], pair_res} + {buf_rd[BufW-1], buf_rd};
  assign pool_res = sum4[DATA_WIDTH+1:2];
`else
  assign pair_res = ($signed(in_data) > $signed(pix_q)) ? in_data : pix_q;
  assign pool_res = ($signed(pair_res) > $signed(buf_rd)) ? pair_res : buf_rd;
`endif

  pool_line_buffer #(
    .Width (BufW),
    .Depth (Depth),
    .AddrW (AddrW)
  ) u_line_buffer (
    .clk   (clk),
    .we    (wr_en),
    .waddr (pair_idx),
    .wdata (pair_res),
    .raddr (pair_idx),
    .rdata (buf_rd)
  );

  always_comb begin
    state_d      = state_q;
    frame_done_d = 1'b0;
    unique case (state_q)
      IDLE:     if (pooling_signal) state_d = ROW_EVEN;
      ROW_EVEN: if (accept && col_last) state_d = ROW_ODD;
      ROW_ODD:  if (accept && col_last) state_d = row_last ? DRAIN : ROW_EVEN;
      DRAIN: begin
        if (!out_valid_q || out_ready) begin
          state_d      = IDLE;
          frame_done_d = 1'b1;
        end
      end
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      pix_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        col_q <= col_last ? '0 : col_q + 1'b1;
        if (col_last) row_q <= row_last ? '0 : row_q + 1'b1;
        if (!col_q[0]) pix_q <= in_data;
      end
      if (emit) begin
        out_data_q  <= pool_res;
        out_valid_q <= 1'b1;
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign ready_write_from_pooling = out_valid_q;
  assign out_data                 = out_data_q;
  assign frame_done               = frame_done_q;

endmodule
